// File: rtl/sfx_pkg.sv
// Shared constants for the sound-effect sequencer: effect ids, rest code
// and FSM state encodings.
package sfx_pkg;
  localparam int SFX_WIN   = 0;
  localparam int SFX_LOSE  = 1;
  localparam int SFX_LIFE  = 2;
  localparam int SFX_SCORE = 3;
  localparam int SFX_CLICK = 4;
  localparam int SFX_SPARE = 5;

  localparam int NOTE_REST = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
endpackage

// File: rtl/sfx_rom.sv
// Melody tables: combinational (id, step) -> note, duration in ticks, last flag.
module sfx_rom
  import sfx_pkg::*;
#(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 8,
  parameter int ID_W   = 3,
  parameter int STEP_W = 5
) (
  input  logic [ID_W-1:0]   id,
  input  logic [STEP_W-1:0] step,
  output logic [NOTE_W-1:0] rom_note,
  output logic [DUR_W-1:0]  rom_dur,
  output logic              rom_last
);
  int   n, d;
  logic l;

  // Steps past the end of a table read as a rest marked last.
  always_comb begin
    n = NOTE_REST;
    d = 1;
    l = 1'b1;
    case (int'(id))
      SFX_WIN: case (int'(step))
        0: begin n = 25; d = 10; l = 1'b0; end
        1: begin n = 29; d = 10; l = 1'b0; end
        2: begin n = 32; d = 20; end
        default: ;
      endcase
      SFX_LOSE: case (int'(step))
        0: begin n = 12; d = 20; l = 1'b0; end
        1: begin n = 10; d = 20; l = 1'b0; end
        2: begin n = 8;  d = 40; end
        default: ;
      endcase
      SFX_LIFE: case (int'(step))
        0: begin n = 20; d = 10; l = 1'b0; end
        1: begin n = 24; d = 10; end
        default: ;
      endcase
      SFX_SCORE: case (int'(step))
        0: begin n = 13; d = 30; l = 1'b0; end
        1: begin n = 17; d = 30; l = 1'b0; end
        2: begin n = 20; d = 30; l = 1'b0; end
        3: begin n = 26; d = 30; end
        default: ;
      endcase
      SFX_CLICK: case (int'(step))
        0: begin n = 19; d = 30; l = 1'b0; end
        1: begin n = 17; d = 20; l = 1'b0; end
        2: begin n = 16; d = 20; l = 1'b0; end
        3: begin n = 15; d = 30; end
        default: ;
      endcase
      SFX_SPARE: case (int'(step))
        0: begin n = 40; d = 0; l = 1'b0; end
        1: begin n = 41; d = 2; end
        default: ;
      endcase
      default: ;
    endcase
  end

  assign rom_note = NOTE_W'(n);
  assign rom_dur  = DUR_W'(d);
  assign rom_last = l;
endmodule

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: edge-detected triggers, fixed-priority pre-emptive
// arbitration, melody stepping at a prescaled tick with optional gaps.
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter  int NOTE_W    = 6,
  parameter  int DUR_W     = 8,
  parameter  int NUM_SFX   = 6,
  parameter  int MAX_STEPS = 32,
  parameter  int TICK_DIV  = 131072,
  parameter  int GAP_TICKS = 0,
  localparam int ID_W      = $clog2(NUM_SFX),
  localparam int STEP_W    = $clog2(MAX_STEPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_SFX-1:0] trig,
  output logic [NOTE_W-1:0]  note,
  output logic               busy,
  output logic [ID_W-1:0]    active_id,
  output logic               done
);
  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  logic [PS_W-1:0]    ps;
  logic               tick;
  logic [NUM_SFX-1:0] trig_q, pending, rise, clr_mask;
  logic [1:0]         state;
  logic [STEP_W-1:0]  step, ld_step;
  logic [DUR_W-1:0]   remaining, ld_dur, ld_len;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_q, ld_last;
  logic [NOTE_W-1:0]  ld_note;
  logic [ID_W-1:0]    win_id, ld_id;
  logic               have, is_last, finish, pick, start_new, advance;

  assign tick = (ps == PS_W'(TICK_DIV - 1));
  assign rise = trig & ~trig_q;
  assign have = |pending;

  always_comb begin
    win_id = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--)
      if (pending[i]) win_id = ID_W'(i);
  end

  assign is_last   = last_q | (step == STEP_W'(MAX_STEPS - 1));
  assign finish    = (state == ST_PLAY) && (remaining == DUR_W'(1)) && is_last;
  // A new effect starts from idle, on pre-emption, or chained onto a natural finish.
  assign pick      = have && ((state == ST_IDLE) || (win_id <= active_id) || finish);
  assign start_new = tick && pick;
  assign advance   = tick && (((state == ST_PLAY) && (remaining == DUR_W'(1)) && !is_last
                               && (GAP_TICKS == 0))
                              || ((state == ST_GAP) && (gap_cnt == GAP_W'(1))));
  assign clr_mask  = start_new ? (NUM_SFX'(1) << win_id) : '0;

  // The ROM is addressed with the entry about to be loaded; its last flag is latched.
  assign ld_id   = pick ? win_id : active_id;
  assign ld_step = pick ? '0 : step + STEP_W'(1);
  assign ld_len  = (ld_dur == '0) ? DUR_W'(1) : ld_dur;

  sfx_rom #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ID_W(ID_W), .STEP_W(STEP_W)) u_rom (
    .id       (ld_id),
    .step     (ld_step),
    .rom_note (ld_note),
    .rom_dur  (ld_dur),
    .rom_last (ld_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps        <= '0;
      trig_q    <= '0;
      pending   <= '0;
      state     <= ST_IDLE;
      step      <= '0;
      remaining <= '0;
      gap_cnt   <= '0;
      last_q    <= 1'b0;
      note      <= '0;
      busy      <= 1'b0;
      active_id <= '0;
      done      <= 1'b0;
    end else begin
      ps     <= tick ? '0 : ps + PS_W'(1);
      trig_q <= trig;
      done   <= 1'b0;
      if (!enable) begin
        state   <= ST_IDLE;
        note    <= NOTE_W'(NOTE_REST);
        busy    <= 1'b0;
        pending <= '0;
      end else begin
        pending <= (pending & ~clr_mask) | rise;
        if (tick) begin
          // done marks any natural finish, including one chained into a pending effect.
          done <= finish;
          if (start_new) begin
            active_id <= win_id;
            step      <= '0;
            note      <= ld_note;
            remaining <= ld_len;
            last_q    <= ld_last;
            busy      <= 1'b1;
            state     <= ST_PLAY;
          end else if (advance) begin
            step      <= ld_step;
            note      <= ld_note;
            remaining <= ld_len;
            last_q    <= ld_last;
            state     <= ST_PLAY;
          end else if (state == ST_PLAY) begin
            if (remaining != DUR_W'(1)) begin
              remaining <= remaining - DUR_W'(1);
            end else if (is_last) begin
              state <= ST_IDLE;
              note  <= NOTE_W'(NOTE_REST);
              busy  <= 1'b0;
            end else begin
              state   <= ST_GAP;
              note    <= NOTE_W'(NOTE_REST);
              gap_cnt <= GAP_W'(GAP_TICKS);
            end
          end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
      end
    end
  end
endmodule
